// File: rtl/output_scaler_pc_if.sv
// Stream interface for output_scaler_pc.
//   master side (producer/consumer around the scaler): drives wx_valid_i, wx_i, y_ready_i
//   slave side (the scaler): drives wx_ready_o, y_valid_o, y_o
//   wx_i : numElements x elementWidth signed partial sums, lane 0 in the LSBs
//   y_o  : numElements x outputWidth signed results, lane 0 in the LSBs
interface output_scaler_pc_if #(
   parameter int unsigned numElements  = 4,
   parameter int unsigned elementWidth = 16,
   parameter int unsigned outputWidth  = 8
);
   logic                                   wx_valid_i;
   logic                                   wx_ready_o;
   logic [numElements-1:0][elementWidth-1:0] wx_i;
   logic                                   y_valid_o;
   logic                                   y_ready_i;
   logic [numElements-1:0][outputWidth-1:0]  y_o;

   modport master (
      output wx_valid_i, wx_i, y_ready_i,
      input  wx_ready_o, y_valid_o, y_o
   );

   modport slave (
      input  wx_valid_i, wx_i, y_ready_i,
      output wx_ready_o, y_valid_o, y_o
   );
endinterface

// File: rtl/output_scaler_pc.sv
// Per-channel requantiser: scale, round-half-up shift, zero point, optional ReLU, saturate.
// Three-stage pipeline (S1 multiply, S2 round/offset, S3 clamp = output register).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   cfg_we/lane/scale/shift : per-lane scale/shift register write
//   cfg_per_lane, cfg_zero_point, cfg_relu_en : sampled per beat at acceptance
//   bus               : wx input stream and y output stream (slave modport)
//   clear_stats_i     : zero the saturation counter (wins over an increment)
//   sat_count_o       : saturating count of clamped elements
//   busy_o            : any pipeline stage holds a beat
module output_scaler_pc #(
   parameter int unsigned numElements    = 4,
   parameter int unsigned elementWidth   = 16,
   parameter int unsigned outputWidth    = 8,
   parameter int unsigned fixedPointBits = 16,
   parameter int unsigned shiftBits      = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cfg_we,
   input  logic [$clog2(numElements)-1:0] cfg_lane,
   input  logic [fixedPointBits-1:0]      cfg_scale,
   input  logic [shiftBits-1:0]           cfg_shift,
   input  logic                           cfg_per_lane,
   input  logic [outputWidth-1:0]         cfg_zero_point,
   input  logic                           cfg_relu_en,
   output_scaler_pc_if.slave              bus,
   input  logic                           clear_stats_i,
   output logic [15:0]                    sat_count_o,
   output logic                           busy_o
);
   localparam int unsigned prodWidth = elementWidth + fixedPointBits + 1;
   localparam int unsigned maxShift  = fixedPointBits + (2 ** shiftBits) - 1;
   // wide enough for p and for the 2^(t-1) rounding term at the largest shift
   localparam int unsigned sumWidth  = ((prodWidth > maxShift + 1) ? prodWidth : maxShift + 1) + 1;
   localparam int unsigned tWidth    = $clog2(maxShift + 1);
   localparam int unsigned rndWidth  = prodWidth - fixedPointBits + 1;
   localparam int unsigned zWidth    = ((rndWidth > outputWidth) ? rndWidth : outputWidth) + 1;
   localparam int unsigned cntWidth  = $clog2(numElements + 1);
   localparam logic signed [outputWidth-1:0] maxOut = {1'b0, {(outputWidth-1){1'b1}}};
   localparam logic signed [outputWidth-1:0] minOut = {1'b1, {(outputWidth-1){1'b0}}};

   logic [fixedPointBits-1:0] scale_q [numElements];
   logic [shiftBits-1:0]      shift_q [numElements];

   logic                          s1_valid;
   logic signed [prodWidth-1:0]   s1_p     [numElements];
   logic [shiftBits-1:0]          s1_shift [numElements];
   logic signed [outputWidth-1:0] s1_zp;
   logic                          s1_relu;

   logic                          s2_valid;
   logic signed [zWidth-1:0]      s2_z [numElements];
   logic signed [outputWidth-1:0] s2_zp;
   logic                          s2_relu;

   logic                                    y_valid_q;
   logic [numElements-1:0][outputWidth-1:0] y_q;
   logic [15:0]                             sat_count_q;

   logic stall_c, adv_c, accept_c;

   assign stall_c        = y_valid_q & ~bus.y_ready_i;
   assign adv_c          = ~stall_c;
   assign accept_c       = bus.wx_valid_i & adv_c;
   assign bus.wx_ready_o = adv_c;
   assign bus.y_valid_o  = y_valid_q;
   assign bus.y_o        = y_q;
   assign sat_count_o    = sat_count_q;
   assign busy_o         = s1_valid | s2_valid | y_valid_q;

   // S1: select effective scale/shift and multiply
   logic [fixedPointBits-1:0]   scale_sel_c [numElements];
   logic [shiftBits-1:0]        shift_sel_c [numElements];
   logic signed [prodWidth-1:0] p_c         [numElements];

   always_comb begin
      for (int i = 0; i < int'(numElements); i++) begin
         scale_sel_c[i] = cfg_per_lane ? scale_q[i] : scale_q[0];
         shift_sel_c[i] = cfg_per_lane ? shift_q[i] : shift_q[0];
         p_c[i] = prodWidth'($signed(bus.wx_i[i])) *
                  prodWidth'($signed({1'b0, scale_sel_c[i]}));
      end
   end

   // S2: round half toward +inf at bit t, then add zero point
   logic [tWidth-1:0]          t_c    [numElements];
   logic [sumWidth-1:0]        half_c [numElements];
   logic signed [sumWidth-1:0] sum_c  [numElements];
   logic signed [sumWidth-1:0] rsh_c  [numElements];
   logic signed [zWidth-1:0]   z_c    [numElements];

   always_comb begin
      for (int i = 0; i < int'(numElements); i++) begin
         t_c[i]    = tWidth'(fixedPointBits) + tWidth'(s1_shift[i]);
         half_c[i] = (sumWidth'(1'b1) << t_c[i]) >> 1;
         sum_c[i]  = sumWidth'(s1_p[i]) + $signed(half_c[i]);
         rsh_c[i]  = sum_c[i] >>> t_c[i];
         z_c[i]    = zWidth'(rndWidth'(rsh_c[i])) + zWidth'(s1_zp);
      end
   end

   // S3: clamp; only range overflow counts as saturation, not the ReLU floor
   logic signed [outputWidth-1:0]           lo_c;
   logic                                    sat_hi_c [numElements];
   logic                                    sat_lo_c [numElements];
   logic [numElements-1:0][outputWidth-1:0] y_c;
   logic [cntWidth-1:0]                     nsat_c;
   logic [16:0]                             cnt_sum_c;

   always_comb begin
      lo_c   = s2_relu ? s2_zp : minOut;
      nsat_c = '0;
      y_c    = '0;
      for (int i = 0; i < int'(numElements); i++) begin
         sat_hi_c[i] = s2_z[i] > zWidth'(maxOut);
         sat_lo_c[i] = s2_z[i] < zWidth'(minOut);
         if (sat_hi_c[i])                     y_c[i] = maxOut;
         else if (s2_z[i] < zWidth'(lo_c))    y_c[i] = lo_c;
         else                                 y_c[i] = outputWidth'(s2_z[i]);
         nsat_c = nsat_c + cntWidth'(sat_hi_c[i] | sat_lo_c[i]);
      end
      cnt_sum_c = {1'b0, sat_count_q} + 17'(nsat_c);
   end

   // per-lane configuration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(numElements); i++) begin
            scale_q[i] <= '0;
            shift_q[i] <= '0;
         end
      end else if (cfg_we) begin
         scale_q[cfg_lane] <= cfg_scale;
         shift_q[cfg_lane] <= cfg_shift;
      end
   end

   // valid bits and output register; everything holds on stall
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         y_valid_q <= 1'b0;
         y_q       <= '0;
      end else if (adv_c) begin
         s1_valid  <= accept_c;
         s2_valid  <= s1_valid;
         y_valid_q <= s2_valid;
         if (s2_valid) y_q <= y_c;
      end
   end

   // datapath registers, qualified by the valid bits above
   always_ff @(posedge clk) begin
      if (adv_c) begin
         if (accept_c) begin
            s1_p     <= p_c;
            s1_shift <= shift_sel_c;
            s1_zp    <= $signed(cfg_zero_point);
            s1_relu  <= cfg_relu_en;
         end
         if (s1_valid) begin
            s2_z    <= z_c;
            s2_zp   <= s1_zp;
            s2_relu <= s1_relu;
         end
      end
   end

   // saturation counter; clear has priority
   always_ff @(posedge clk) begin
      if (rst || clear_stats_i) begin
         sat_count_q <= '0;
      end else if (adv_c && s2_valid) begin
         sat_count_q <= cnt_sum_c[16] ? 16'hFFFF : cnt_sum_c[15:0];
      end
   end
endmodule

// File: tb/tb_output_scaler_pc.sv
// Self-checking bench for output_scaler_pc: scoreboard queue of expected beats,
// monitor compares at the falling edge, one task per feature.
module tb_output_scaler_pc;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [1:0]  cfg_lane;
   logic [15:0] cfg_scale;
   logic [4:0]  cfg_shift;
   logic        cfg_per_lane;
   logic [7:0]  cfg_zero_point;
   logic        cfg_relu_en;
   logic        clear_stats_i;
   logic [15:0] sat_count_o;
   logic        busy_o;

   always #5 clk = ~clk;

   output_scaler_pc_if bus ();

   output_scaler_pc dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_we         (cfg_we),
      .cfg_lane       (cfg_lane),
      .cfg_scale      (cfg_scale),
      .cfg_shift      (cfg_shift),
      .cfg_per_lane   (cfg_per_lane),
      .cfg_zero_point (cfg_zero_point),
      .cfg_relu_en    (cfg_relu_en),
      .bus            (bus),
      .clear_stats_i  (clear_stats_i),
      .sat_count_o    (sat_count_o),
      .busy_o         (busy_o)
   );

   typedef struct {
      logic [31:0] y;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          exp_sat  = 0;
   int          m_scale[N];
   int          m_shift[N];
   bit          prev_stall = 1'b0;
   logic [31:0] prev_y;

   always @(posedge clk) cyc <= cyc + 1;

   // output monitor: hold stability under stall, in-order data, latency
   always @(negedge clk) begin
      if (prev_stall) begin
         checks++;
         if (bus.y_valid_o !== 1'b1 || bus.y_o !== prev_y) begin
            failures++;
            $display("FAIL hold_stable: y_valid=%b y=%h, required y_valid=1 y=%h",
                     bus.y_valid_o, bus.y_o, prev_y);
         end
      end
      if (bus.y_valid_o === 1'b1 && bus.y_ready_i === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat: y=%h with no beat outstanding", bus.y_o);
         end else begin
            mon_e = sb.pop_front();
            if (bus.y_o !== mon_e.y) begin
               failures++;
               $display("FAIL beat_data: y=%h required %h", bus.y_o, mon_e.y);
            end
            if (mon_e.lat) begin
               checks++;
               if (cyc - mon_e.acc != 2) begin
                  failures++;
                  $display("FAIL latency: y_valid after %0d edges past accept edge, required 2 (3rd edge)",
                           cyc - mon_e.acc);
               end
            end
         end
      end
      prev_stall = (bus.y_valid_o === 1'b1) && (bus.y_ready_i === 1'b0);
      prev_y     = bus.y_o;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [63:0] wx4(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   function automatic logic [31:0] y4(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   // reference: exact floor((wx*scale + 2^(t-1)) / 2^t) in 64-bit integers
   function automatic logic [7:0] model_lane(input int wx, input int lane, output bit sat);
      int     l;
      longint p, d, num, r, z, lo, zp;
      l   = cfg_per_lane ? lane : 0;
      zp  = longint'($signed(cfg_zero_point));
      p   = longint'(wx) * longint'(m_scale[l]);
      d   = longint'(1) <<< (16 + m_shift[l]);
      num = p + d / 2;
      r   = (num >= 0) ? num / d : -((-num + d - 1) / d);
      z   = r + zp;
      lo  = cfg_relu_en ? zp : -128;
      sat = (z > 127) || (z < -128);
      if (z > 127)     z = 127;
      else if (z < lo) z = lo;
      return 8'(z);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_lane(input int lane, input int sc, input int sh);
      cfg_we    = 1'b1;
      cfg_lane  = 2'(lane);
      cfg_scale = 16'(sc);
      cfg_shift = 5'(sh);
      tick();
      cfg_we = 1'b0;
      m_scale[lane] = sc;
      m_shift[lane] = sh;
   endtask

   task automatic write_all(input int sc, input int sh);
      for (int l = 0; l < N; l++) write_lane(l, sc, sh);
   endtask

   // present one beat, push its expectation when it is certain to be accepted
   task automatic send(input logic [63:0] wx, input logic [31:0] y, input bit lat);
      int   n = 0;
      exp_t e;
      bus.wx_valid_i = 1'b1;
      bus.wx_i       = wx;
      @(negedge clk);
      while (bus.wx_ready_o !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: wx_ready=%b for 100 cycles, required 1", bus.wx_ready_o);
         bus.wx_valid_i = 1'b0;
         return;
      end
      e.y   = y;
      e.acc = cyc + 1;
      e.lat = lat;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.wx_valid_i = 1'b0;
   endtask

   task automatic send_model(input logic [63:0] wx);
      logic [31:0] y;
      logic [15:0] w;
      bit          s;
      for (int l = 0; l < N; l++) begin
         w = wx[16*l +: 16];
         y[8*l +: 8] = model_lane(int'($signed(w)), l, s);
         if (s) exp_sat++;
      end
      if (exp_sat > 65535) exp_sat = 65535;
      send(wx, y, 1'b0);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || busy_o !== 1'b0) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: %0d beats outstanding, busy=%b, required 0/0", sb.size(), busy_o);
         sb.delete();
      end
   endtask

   task automatic check_sat(input int tag);
      checks++;
      if (sat_count_o !== 16'(exp_sat)) begin
         failures++;
         $display("FAIL sat_count_%0d: got %0d required %0d", tag, sat_count_o, exp_sat);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks += 5;
      if (bus.y_valid_o !== 1'b0) begin failures++; $display("FAIL reset_y_valid: %b required 0", bus.y_valid_o); end
      if (busy_o !== 1'b0)        begin failures++; $display("FAIL reset_busy: %b required 0", busy_o); end
      if (sat_count_o !== 16'd0)  begin failures++; $display("FAIL reset_sat: %0d required 0", sat_count_o); end
      if (bus.wx_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: %b required 1", bus.wx_ready_o); end
      if (bus.y_o !== 32'd0)      begin failures++; $display("FAIL reset_y: %h required 0", bus.y_o); end
      tick();
   endtask

   task automatic test_rounding();
      cfg_per_lane = 1'b1; cfg_zero_point = 8'd0; cfg_relu_en = 1'b0;
      write_all(16'h8000, 0);
      send(wx4(100, 101, -101, -100), y4(50, 51, -50, -50), 1'b1);
      drain();
      send(wx4(-101, 100, 101, 0), y4(-50, 50, 51, 0), 1'b1);
      drain();
   endtask

   task automatic test_shift();
      write_all(16'h8000, 2);
      send(wx4(100, -100, 7, 0), y4(13, -12, 1, 0), 1'b1);
      drain();
      write_all(16'h8000, 31);
      send(wx4(100, -100, 32767, -32768), y4(0, 0, 0, 0), 1'b1);
      drain();
      check_sat(0);
   endtask

   task automatic test_saturation();
      write_all(16'hFFFF, 0);
      send(wx4(1000, 1000, 1000, 1000), y4(127, 127, 127, 127), 1'b1);
      exp_sat += 4;
      drain();
      check_sat(1);
      send(wx4(-1000, -1000, -1000, -1000), y4(-128, -128, -128, -128), 1'b1);
      exp_sat += 4;
      drain();
      check_sat(2);
      // clear on the exact edge the saturating beat enters the output stage
      send(wx4(1000, 1000, 1000, 1000), y4(127, 127, 127, 127), 1'b1);
      tick();
      clear_stats_i = 1'b1;
      tick();
      clear_stats_i = 1'b0;
      exp_sat = 0;
      @(negedge clk);
      checks++;
      if (bus.y_valid_o !== 1'b1 || sat_count_o !== 16'd0) begin
         failures++;
         $display("FAIL clear_priority: y_valid=%b sat=%0d required 1 and 0", bus.y_valid_o, sat_count_o);
      end
      tick();
      drain();
      send(wx4(-1000, -1000, -1000, -1000), y4(-128, -128, -128, -128), 1'b1);
      exp_sat += 4;
      drain();
      check_sat(3);
   endtask

   task automatic test_relu();
      write_all(16'h8000, 0);
      cfg_zero_point = 8'd10; cfg_relu_en = 1'b1;
      send(wx4(-50, -50, -50, -50), y4(10, 10, 10, 10), 1'b1);
      drain();
      check_sat(4);
      cfg_relu_en = 1'b0;
      send(wx4(-50, -50, -50, -50), y4(-15, -15, -15, -15), 1'b1);
      drain();
      check_sat(5);
      cfg_zero_point = 8'd0;
   endtask

   task automatic test_per_lane();
      write_lane(0, 16'h4000, 0);
      write_lane(1, 16'h8000, 0);
      write_lane(2, 16'hC000, 0);
      write_lane(3, 16'hFFFF, 0);
      cfg_per_lane = 1'b1;
      send(wx4(400, 400, 400, 400), y4(100, 127, 127, 127), 1'b1);
      exp_sat += 3;
      drain();
      check_sat(6);
      cfg_per_lane = 1'b0;
      send(wx4(40, 40, 40, 40), y4(10, 10, 10, 10), 1'b1);
      drain();
      check_sat(7);
   endtask

   task automatic test_back_to_back();
      int zpv;
      cfg_per_lane = 1'b1;
      for (int l = 0; l < N; l++) write_lane(l, int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
      fork
         begin
            for (int b = 0; b < 8; b++) begin
               zpv            = int'($urandom_range(0, 40)) - 20;
               cfg_zero_point = 8'(zpv);
               cfg_relu_en    = 1'($urandom_range(0, 1));
               send_model(wx4(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
                              int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000));
            end
         end
         begin
            repeat (4) tick();
            bus.y_ready_i = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               checks++;
               if (bus.wx_ready_o !== 1'b0 || bus.y_valid_o !== 1'b1) begin
                  failures++;
                  $display("FAIL stall_ready: wx_ready=%b y_valid=%b required 0 and 1",
                           bus.wx_ready_o, bus.y_valid_o);
               end
               tick();
            end
            bus.y_ready_i = 1'b1;
         end
      join
      drain();
      cfg_zero_point = 8'd0;
      cfg_relu_en    = 1'b0;
      check_sat(8);
   endtask

   task automatic test_reset_midflight();
      cfg_per_lane = 1'b1;
      write_all(16'hFFFF, 0);
      send(wx4(1000, 1000, 1000, 1000), y4(127, 127, 127, 127), 1'b0);
      send(wx4(1000, 1000, 1000, 1000), y4(127, 127, 127, 127), 1'b0);
      send(wx4(1000, 1000, 1000, 1000), y4(127, 127, 127, 127), 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      exp_sat = 0;
      for (int l = 0; l < N; l++) begin m_scale[l] = 0; m_shift[l] = 0; end
      @(negedge clk);
      checks += 4;
      if (bus.y_valid_o !== 1'b0)  begin failures++; $display("FAIL midrst_y_valid: %b required 0", bus.y_valid_o); end
      if (busy_o !== 1'b0)         begin failures++; $display("FAIL midrst_busy: %b required 0", busy_o); end
      if (sat_count_o !== 16'd0)   begin failures++; $display("FAIL midrst_sat: %0d required 0", sat_count_o); end
      if (bus.wx_ready_o !== 1'b1) begin failures++; $display("FAIL midrst_ready: %b required 1", bus.wx_ready_o); end
      tick();
      // scale registers were cleared by reset, so everything maps to zero
      send(wx4(1000, -1000, 32767, -32768), y4(0, 0, 0, 0), 1'b1);
      drain();
      check_sat(9);
   endtask

   initial begin
      rst            = 1'b1;
      cfg_we         = 1'b0;
      cfg_lane       = '0;
      cfg_scale      = '0;
      cfg_shift      = '0;
      cfg_per_lane   = 1'b1;
      cfg_zero_point = '0;
      cfg_relu_en    = 1'b0;
      clear_stats_i  = 1'b0;
      bus.wx_valid_i = 1'b0;
      bus.wx_i       = '0;
      bus.y_ready_i  = 1'b1;
      for (int l = 0; l < N; l++) begin m_scale[l] = 0; m_shift[l] = 0; end

      test_reset();
      test_rounding();
      test_shift();
      test_saturation();
      test_relu();
      test_per_lane();
      test_back_to_back();
      test_reset_midflight();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
